// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel/window widths and window packing for the 3x3 MAC datapath
package cnn_pkg;

   localparam int PIX_BITS = 16;
   localparam int WIN_BITS = 9 * PIX_BITS;
   localparam int IMG_W    = 28;
   localparam int IMG_H    = 28;

   // Row-major 3x3 pack, p[0][0] (top-left) lands in the MSBs.
   function automatic logic [WIN_BITS-1:0] pack_window(input logic [PIX_BITS-1:0] p [3][3]);
      logic [WIN_BITS-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w = {w[WIN_BITS-PIX_BITS-1:0], p[i][j]};
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of pixels, combinational read-before-write
module line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Read sees the old entry even when it is overwritten in the same cycle.
   assign rdata = mem_q[addr];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[addr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to packed 3x3 valid-padding windows
module conv_window_gen
   import cnn_pkg::*;
#(
   parameter int PIX_BITS = cnn_pkg::PIX_BITS,
   parameter int IMG_W    = cnn_pkg::IMG_W,
   parameter int IMG_H    = cnn_pkg::IMG_H
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [PIX_BITS-1:0]      pix_in,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic [9*PIX_BITS-1:0]    window_out,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [$clog2(IMG_H)-1:0] win_row,
   output logic [$clog2(IMG_W)-1:0] win_col,
   output logic                     win_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int WB    = 9 * PIX_BITS;

   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [PIX_BITS-1:0] sr_q [3][3];
   logic [PIX_BITS-1:0] sr_d [3][3];
   logic [WB-1:0]       window_q, window_d;
   logic                win_valid_q, win_valid_d;
   logic [ROW_W-1:0]    win_row_q, win_row_d;
   logic [COL_W-1:0]    win_col_q, win_col_d;
   logic                win_last_q, win_last_d;
   logic [PIX_BITS-1:0] lb0_rd, lb1_rd;
   logic                accept, complete, col_end, row_end;

   assign pix_ready = ~win_valid_q | win_ready;
   assign accept    = pix_valid & pix_ready & ~clr;

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_BITS)) u_lb0 (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .addr  (col_q),
      .wdata (pix_in),
      .rdata (lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_BITS)) u_lb1 (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .addr  (col_q),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   always_comb begin
      col_end     = (col_q == COL_W'(IMG_W - 1));
      row_end     = (row_q == ROW_W'(IMG_H - 1));
      complete    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      col_d       = col_q;
      row_d       = row_q;
      sr_d        = sr_q;
      window_d    = window_q;
      win_valid_d = win_valid_q & ~win_ready;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      win_last_d  = win_last_q;

      if (clr) begin
         col_d       = '0;
         row_d       = '0;
         win_valid_d = 1'b0;
      end else if (accept) begin
         col_d = col_end ? '0 : col_q + COL_W'(1);
         if (col_end) begin
            row_d = row_end ? '0 : row_q + ROW_W'(1);
         end
         for (int r = 0; r < 3; r++) begin
            sr_d[r][0] = sr_q[r][1];
            sr_d[r][1] = sr_q[r][2];
         end
         sr_d[0][2] = lb1_rd;
         sr_d[1][2] = lb0_rd;
         sr_d[2][2] = pix_in;
         // Only windows whose three columns all come from the current rows are emitted.
         if (complete) begin
            win_valid_d = 1'b1;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  window_d = {window_d[WB-PIX_BITS-1:0], sr_d[i][j]};
               end
            end
            win_row_d  = row_q - ROW_W'(2);
            win_col_d  = col_q - COL_W'(2);
            win_last_d = row_end & col_end;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         window_q    <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         win_last_q  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               sr_q[i][j] <= '0;
            end
         end
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         sr_q        <= sr_d;
         window_q    <= window_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         win_last_q  <= win_last_d;
      end
   end

   assign window_out = window_q;
   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign win_last   = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed and gapped-stream checks of conv_window_gen
module tb_conv_window_gen;

   logic         clk = 1'b0;
   logic         rst, clr, pix_valid, win_ready;
   logic [15:0]  pix_in;
   logic         pix_ready, win_valid, win_last;
   logic [143:0] window_out;
   logic [4:0]   win_row, win_col;
   int           errs = 0;
   int           checks = 0;
   int           lasts;

   always #5 clk = ~clk;

   conv_window_gen dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .window_out (window_out),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_last   (win_last)
   );

   task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // seed 0 gives the ramp image pixel = row*28 + col
   function automatic logic [15:0] pixel(input int seed, input int r, input int c);
      return 16'((r * 28 + c) * (2 * seed + 1) + seed * 977);
   endfunction

   function automatic logic [143:0] exp_win(input int seed, input int r, input int c);
      logic [143:0] w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[127:0], pixel(seed, r + i, c + j)};
      return w;
   endfunction

   // Streams npix pixels (frames back to back, frame f uses seed+f) and checks
   // windows until stop_k have been consumed.
   task automatic run(input int npix, input int seed, input int pv_pct, input int wr_pct,
                      input int stall_k, input int stop_k, input bit ramp_chk, output int nlast);
      int p = 0, k = 0, cyc = 0, acc58 = -1, stall = 0;
      int f, wi, r, c;
      nlast = 0;
      while (!(p == npix && k >= stop_k) && cyc < npix * 8 + 500) begin
         @(negedge clk);
         pix_valid = (p < npix) && ($urandom_range(99) < pv_pct);
         pix_in    = pixel(seed + p / 784, (p % 784) / 28, p % 28);
         win_ready = ($urandom_range(99) < wr_pct);
         if (win_valid && k == stall_k && stall < 5) begin
            win_ready = 1'b0;
            stall++;
         end
         #1;
         if (win_valid && !win_ready && k == stall_k) begin
            check("bp_ready", pix_ready, 0);
            check("bp_hold", window_out, exp_win(seed + k / 676, (k % 676) / 26, k % 26));
         end
         if (win_valid && win_ready) begin
            f  = k / 676;
            wi = k % 676;
            r  = wi / 26;
            c  = wi % 26;
            check("win", window_out, exp_win(seed + f, r, c));
            check("row", win_row, r);
            check("col", win_col, c);
            check("last", win_last, (wi == 675));
            if (win_last) nlast++;
            if (ramp_chk && k == 0) begin
               check("first", window_out, {16'd0, 16'd1, 16'd2, 16'd28, 16'd29, 16'd30,
                                           16'd56, 16'd57, 16'd58});
               check("latency", cyc - acc58, 1);
            end
            if (ramp_chk && k == 25) check("r0_end", window_out[15:0], 83);
            if (ramp_chk && k == 26)
               check("wrap", window_out, {16'd28, 16'd29, 16'd30, 16'd56, 16'd57, 16'd58,
                                          16'd84, 16'd85, 16'd86});
            if (ramp_chk && wi == 675) check("final_p33", window_out[15:0], 783);
            k++;
         end
         if (pix_valid && pix_ready) begin
            if (p % 784 == 58) acc58 = cyc;
            p++;
         end
         cyc++;
      end
      check("count", k, stop_k);
      check("pixels", p, npix);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; pix_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", win_valid, 0);
      check("rst_win", window_out, 0);
      check("rst_ready", pix_ready, 1);
      rst = 1'b0;

      // Ramp frame, full rate
      run(784, 0, 100, 100, -1, 676, 1'b1, lasts);
      check("ramp_lasts", lasts, 1);

      // Backpressure on window 10
      run(784, 0, 100, 100, 10, 676, 1'b1, lasts);

      // Two frames with random gaps on both sides
      run(1568, 5, 70, 60, -1, 1352, 1'b0, lasts);
      check("rand_lasts", lasts, 2);

      // Reset mid-stream with a window pending, then a clean frame
      run(400, 9, 100, 100, -1, 317, 1'b0, lasts);
      @(negedge clk);
      pix_valid = 1'b0; win_ready = 1'b0;
      #1;
      check("pend_valid", win_valid, 1);
      check("pend_row", win_row, 12);
      check("pend_col", win_col, 5);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", win_valid, 0);
      check("arst_win", window_out, 0);
      check("arst_ready", pix_ready, 1);
      check("arst_row", win_row, 0);
      check("arst_last", win_last, 0);
      @(negedge clk);
      rst = 1'b0;
      run(784, 0, 100, 100, -1, 676, 1'b1, lasts);

      // clr after pixel 300 drops the pending window, next frame is clean
      run(300, 3, 100, 100, -1, 225, 1'b0, lasts);
      @(negedge clk);
      pix_valid = 1'b0; win_ready = 1'b0;
      #1;
      check("clr_pend", win_valid, 1);
      check("clr_pend_col", win_col, 17);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("clr_valid", win_valid, 0);
      check("clr_ready", pix_ready, 1);
      run(784, 0, 100, 100, -1, 676, 1'b1, lasts);
      check("clr_lasts", lasts, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
